// File: rtl/pll_lock_rst_ctrl.sv
// Reset/lock sequencer for the baseband PLL: pulses pll_rst, qualifies extlock as stable,
// then releases the system reset after a settling delay. Retries on timeout, re-sequences on loss.
module pll_lock_rst_ctrl #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned RELEASE_DELAY  = 256,
  parameter int unsigned MAX_RETRIES    = 7,
  parameter int unsigned CNT_W          = 17
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       extlock,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       sys_rst_out,
  output logic       pll_ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRelease  = 3'd3,
    StRun      = 3'd4,
    StFail     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] PllRstLast  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] ReleaseLast = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [3:0]       MaxRetries  = 4'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [1:0]       sync_q;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             restart;
  logic             lock_s;

  assign lock_s = sync_q[1];

  // extlock is asynchronous to refclk
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], extlock};
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    restart = 1'b0;
    if (soft_rst_req) begin
      state_d = StPllRst;
      retry_d = 4'd0;
      restart = 1'b1;
    end else begin
      case (state_q)
        StPllRst: begin
          if (cnt_q == PllRstLast) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
          end else if (cnt_q == TimeoutLast) begin
            if (retry_q == MaxRetries) begin
              state_d = StFail;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = StPllRst;
            end
          end
        end
        StStable: begin
          // A lock glitch restarts the wait without charging a retry
          if (!lock_s) state_d = StWaitLock;
          else if (cnt_q == StableLast) state_d = StRelease;
        end
        StRelease: begin
          if (!lock_s) state_d = StPllRst;
          else if (cnt_q == ReleaseLast) state_d = StRun;
        end
        StRun: begin
          if (!lock_s) state_d = StPllRst;
        end
        StFail: begin
          state_d = StFail;
        end
        default: begin
          state_d = StPllRst;
        end
      endcase
    end

    if (state_d == StRun) retry_d = 4'd0;

    cnt_d = (restart || (state_d != state_q)) ? '0 : cnt_q + CNT_W'(1);

    // Outputs decode the next state so they change on the same edge as the state
    pll_rst_d = (state_d == StPllRst);
    sys_rst_d = (state_d != StRun);
    ready_d   = (state_d == StRun);
    fail_d    = (state_d == StFail);
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_q   <= StPllRst;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst_out = sys_rst_q;
  assign pll_ready   = ready_q;
  assign fail        = fail_q;
  assign retry_cnt   = retry_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pll_lock_rst_ctrl.sv
// Directed/randomized bench for pll_lock_rst_ctrl against a cycle reference model of the
// sequencing rules, plus fixed latency and reset-value expectations.
module tb_pll_lock_rst_ctrl;

  localparam int unsigned PR = 4;
  localparam int unsigned TO = 32;
  localparam int unsigned ST = 8;
  localparam int unsigned RD = 4;
  localparam int unsigned MR = 2;
  localparam int          LAT = 3 + ST + RD;          // extlock rise to release
  localparam int          LAT_FROM_RST = PR + 1 + ST + RD;  // lock already high at restart

  logic       refclk = 1'b0;
  logic       reset;
  logic       extlock;
  logic       soft_rst_req;
  logic       pll_rst;
  logic       sys_rst_out;
  logic       pll_ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase number, cycles spent in phase, retries, extlock history
  int m_state;
  int m_age;
  int m_retry;
  bit hist_q[$];

  pll_lock_rst_ctrl #(
    .PLL_RST_CYCLES(PR),
    .LOCK_TIMEOUT  (TO),
    .LOCK_STABLE   (ST),
    .RELEASE_DELAY (RD),
    .MAX_RETRIES   (MR),
    .CNT_W         (6)
  ) dut (
    .refclk      (refclk),
    .reset       (reset),
    .extlock     (extlock),
    .soft_rst_req(soft_rst_req),
    .pll_rst     (pll_rst),
    .sys_rst_out (sys_rst_out),
    .pll_ready   (pll_ready),
    .fail        (fail),
    .retry_cnt   (retry_cnt),
    .state_o     (state_o)
  );

  always #5 refclk = ~refclk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_age   = 0;
    m_retry = 0;
    hist_q  = {1'b0, 1'b0};
  endtask

  task automatic model_step();
    bit ls;
    int nxt;
    ls = hist_q.pop_front();
    hist_q.push_back(bit'(extlock));
    nxt = m_state;
    if (soft_rst_req === 1'b1) begin
      nxt = 0;
      m_retry = 0;
    end else begin
      if (m_state == 0 && m_age == PR - 1) nxt = 1;
      if (m_state == 1) begin
        if (ls) nxt = 2;
        else if (m_age == TO - 1) begin
          if (m_retry == MR) nxt = 5;
          else begin
            m_retry++;
            nxt = 0;
          end
        end
      end
      if (m_state == 2) nxt = !ls ? 1 : (m_age == ST - 1) ? 3 : 2;
      if (m_state == 3) nxt = !ls ? 0 : (m_age == RD - 1) ? 4 : 3;
      if (m_state == 4 && !ls) nxt = 0;
    end
    m_age = (nxt != m_state || soft_rst_req === 1'b1) ? 0 : m_age + 1;
    m_state = nxt;
    if (m_state == 4) m_retry = 0;
  endtask

  task automatic chk_model(input string where);
    chk({where, ".state"},   32'(state_o),     32'(m_state));
    chk({where, ".pll_rst"}, 32'(pll_rst),     32'(m_state == 0));
    chk({where, ".sys_rst"}, 32'(sys_rst_out), 32'(m_state != 4));
    chk({where, ".ready"},   32'(pll_ready),   32'(m_state == 4));
    chk({where, ".fail"},    32'(fail),        32'(m_state == 5));
    chk({where, ".retry"},   32'(retry_cnt),   32'(m_retry));
  endtask

  task automatic chk_reset_vals(input string where);
    chk({where, ".state"},   32'(state_o),     32'd0);
    chk({where, ".pll_rst"}, 32'(pll_rst),     32'd1);
    chk({where, ".sys_rst"}, 32'(sys_rst_out), 32'd1);
    chk({where, ".ready"},   32'(pll_ready),   32'd0);
    chk({where, ".fail"},    32'(fail),        32'd0);
    chk({where, ".retry"},   32'(retry_cnt),   32'd0);
  endtask

  task automatic tick(input string where);
    @(posedge refclk);
    if (reset === 1'b1) model_reset();
    else model_step();
    #1;
    chk_model(where);
  endtask

  task automatic run_until(input int st, input string where);
    for (int i = 0; i < 500 && m_state != st; i++) tick(where);
  endtask

  task automatic edges_to_release(input string where, output int n);
    n = 0;
    do begin
      tick(where);
      n++;
    end while (sys_rst_out !== 1'b0 && n < 300);
  endtask

  task automatic soft_pulse(input string where);
    soft_rst_req = 1'b1;
    tick(where);
    soft_rst_req = 1'b0;
    chk({where, ".state0"}, 32'(state_o),   32'd0);
    chk({where, ".retry0"}, 32'(retry_cnt), 32'd0);
    chk({where, ".fail0"},  32'(fail),      32'd0);
    chk({where, ".pllrst"}, 32'(pll_rst),   32'd1);
  endtask

  task automatic async_reset(input string where);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk_reset_vals(where);
    tick({where, "_hold"});
    reset = 1'b0;
  endtask

  initial begin
    int  n;
    int  k;
    int  mx;
    bit  saw;
    reset = 1'b1;
    extlock = 1'b0;
    soft_rst_req = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("reset");
    repeat (2) tick("reset_clk");
    reset = 1'b0;

    // 1: pll_rst window, then lock at cycle 10
    for (int i = 1; i <= 4; i++) begin
      tick("t1_pllrst");
      chk("t1_pll_rst_window", 32'(pll_rst), 32'(i < 4));
    end
    repeat (6) tick("t1_wait");
    extlock = 1'b1;
    edges_to_release("t1_lock", n);
    chk("t1_release_latency", 32'(n), 32'(LAT));
    chk("t1_ready", 32'(pll_ready), 32'd1);
    chk("t1_retry", 32'(retry_cnt), 32'd0);

    // 4: loss of lock in RUN, then re-lock
    repeat ($urandom_range(1, 20)) tick("t4_run");
    extlock = 1'b0;
    n = 0;
    do begin
      tick("t4_drop");
      n++;
    end while (pll_rst !== 1'b1 && n < 50);
    chk("t4_drop_latency", 32'(n), 32'd3);
    chk("t4_sys_rst", 32'(sys_rst_out), 32'd1);
    chk("t4_ready", 32'(pll_ready), 32'd0);
    run_until(1, "t4_to_wait");
    repeat ($urandom_range(0, 5)) tick("t4_wait");
    extlock = 1'b1;
    edges_to_release("t4_relock", n);
    chk("t4_relock_latency", 32'(n), 32'(LAT));

    // 3: one-cycle extlock glitch during STABLE
    extlock = 1'b0;
    run_until(1, "t3_to_wait");
    extlock = 1'b1;
    run_until(2, "t3_to_stable");
    k = $urandom_range(0, 4);
    repeat (k) tick("t3_stable");
    extlock = 1'b0;
    tick("t3_glitch");
    extlock = 1'b1;
    saw = 1'b0;
    mx = 0;
    n = 0;
    do begin
      tick("t3_recover");
      n++;
      if (state_o === 3'd1) saw = 1'b1;
      if (int'(retry_cnt) > mx) mx = int'(retry_cnt);
    end while (sys_rst_out !== 1'b0 && n < 300);
    chk("t3_saw_wait_lock", 32'(saw), 32'd1);
    chk("t3_no_retry", 32'(mx), 32'd0);
    chk("t3_release_after_relock", 32'(n), 32'(LAT));

    // 2: extlock stuck low -> retries then FAIL
    extlock = 1'b0;
    saw = 1'b0;
    n = 0;
    do begin
      tick("t2_timeout");
      n++;
      if (retry_cnt === 4'd1) saw = 1'b1;
    end while (fail !== 1'b1 && n < 400);
    chk("t2_fail_edges", 32'(n), 32'(3 + (MR + 1) * (PR + TO)));
    chk("t2_saw_retry1", 32'(saw), 32'd1);
    chk("t2_state", 32'(state_o), 32'd5);
    chk("t2_pll_rst", 32'(pll_rst), 32'd0);
    chk("t2_sys_rst", 32'(sys_rst_out), 32'd1);
    chk("t2_retry", 32'(retry_cnt), 32'(MR));

    // 5: soft reset in FAIL, WAIT_LOCK (with a retry pending) and RUN
    repeat ($urandom_range(1, 10)) tick("t5_fail_hold");
    chk("t5_fail_held", 32'(fail), 32'd1);
    soft_pulse("t5_soft_fail");
    for (int i = 0; i < 300 && !(m_state == 1 && m_retry == 1); i++) tick("t5_to_retry");
    repeat ($urandom_range(0, 10)) tick("t5_wait");
    chk("t5_retry_pending", 32'(retry_cnt), 32'd1);
    soft_pulse("t5_soft_wait");
    extlock = 1'b1;
    edges_to_release("t5_lock", n);
    chk("t5_lock_latency", 32'(n), 32'(LAT_FROM_RST));
    repeat ($urandom_range(1, 10)) tick("t5_run");
    soft_pulse("t5_soft_run");
    chk("t5_sys_rst", 32'(sys_rst_out), 32'd1);
    chk("t5_ready", 32'(pll_ready), 32'd0);

    // 6: async reset in RELEASE and in FAIL
    run_until(3, "t6_to_release");
    repeat ($urandom_range(0, 2)) tick("t6_release");
    async_reset("t6_rst_release");
    edges_to_release("t6_reseq1", n);
    chk("t6_reseq1_latency", 32'(n), 32'(LAT_FROM_RST));
    extlock = 1'b0;
    run_until(5, "t6_to_fail");
    chk("t6_in_fail", 32'(fail), 32'd1);
    async_reset("t6_rst_fail");
    extlock = 1'b1;
    edges_to_release("t6_reseq2", n);
    chk("t6_reseq2_latency", 32'(n), 32'(LAT_FROM_RST));
    chk("t6_reseq2_retry", 32'(retry_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
